// File: rtl/ccc_cmd_arbiter_if.sv
// ccc_cmd_arbiter_if
//   Bundle between the driver-button front end and the cruise-control core.
//   Carries the raw button levels and vehicle speed in, and the one-hot command
//   pulses, synchronized brake, set-reject pulse, queue depths and busy flag out.
//   master : the side that owns the buttons and consumes the commands
//   slave  : the arbiter itself
interface ccc_cmd_arbiter_if #(
   parameter int PW = 3
);
   logic [6:0]    spd;
   logic          set_in;
   logic          resume_in;
   logic          accel_in;
   logic          coast_in;
   logic          cancel_in;
   logic          brake_in;
   logic          cmd_set;
   logic          cmd_resume;
   logic          cmd_accel;
   logic          cmd_coast;
   logic          cmd_cancel;
   logic          brake_o;
   logic          set_rej;
   logic [PW-1:0] pend_accel;
   logic [PW-1:0] pend_coast;
   logic          busy;

   modport master (
      output spd, set_in, resume_in, accel_in, coast_in, cancel_in, brake_in,
      input  cmd_set, cmd_resume, cmd_accel, cmd_coast, cmd_cancel,
      input  brake_o, set_rej, pend_accel, pend_coast, busy
   );

   modport slave (
      input  spd, set_in, resume_in, accel_in, coast_in, cancel_in, brake_in,
      output cmd_set, cmd_resume, cmd_accel, cmd_coast, cmd_cancel,
      output brake_o, set_rej, pend_accel, pend_coast, busy
   );
endinterface

// File: rtl/ccc_cmd_arbiter.sv
// ccc_cmd_arbiter
//   Conditions the cruise-control buttons (2-FF sync, debounce, press-edge detect),
//   queues the presses and issues them to the core as one-hot single-cycle pulses
//   under fixed priority cancel > set > resume > accel > coast, with a forced idle
//   gap after each command. Brake skips debounce and flushes speed requests.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ccc_cmd_arbiter_if.slave (buttons/speed in; cmd_*, brake_o, set_rej,
//          pend_accel, pend_coast, busy out)
//
// state | meaning
// IDLE  | evaluate pending requests, grant highest priority (or reject a low-speed set)
// ISSUE | exactly one cmd_* high this cycle
// GAP   | forced idle spacing before the next grant
module ccc_cmd_arbiter #(
   parameter int DB_CYC      = 4,
   parameter int GAP_CYC     = 3,
   parameter int PW          = 3,
   parameter int MIN_SET_SPD = 40
) (
   input logic               clk,
   input logic               rst,
   ccc_cmd_arbiter_if.slave  bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   // button index: 0 set, 1 resume, 2 accel, 3 coast, 4 cancel
   localparam int NB  = 5;
   localparam int DBW = $clog2(DB_CYC + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

   // IDLE spends one cycle of the spacing, so GAP covers the remaining GAP_CYC-1
   localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC < 2) ? 0 : GAP_CYC - 2);

   localparam logic [6:0]    MIN_SPD = 7'(MIN_SET_SPD);
   localparam logic [PW-1:0] PMAX    = '1;

   logic [NB-1:0]  raw, sync1, sync2, db_lvl, press;
   logic [DBW-1:0] db_cnt [NB];
   logic           brk1, brk2;

   logic [1:0]     state;
   logic [GW-1:0]  gap_cnt;
   logic [NB-1:0]  cmd_q;
   logic           set_rej_q;

   logic           flag_set, flag_resume, flag_cancel;
   logic [PW-1:0]  pend_accel, pend_coast;

   logic           ev_set, ev_resume, ev_accel, ev_coast, ev_cancel;
   logic           idle, set_ok;
   logic           take_cancel, take_set, take_resume, take_accel, take_coast;
   logic           flag_set_nxt, flag_resume_nxt, flag_cancel_nxt;
   logic [PW-1:0]  acc_eff, coa_eff, acc_nxt, coa_nxt;

   assign raw = {bus.cancel_in, bus.coast_in, bus.accel_in, bus.resume_in, bus.set_in};

   // synchronizers and per-button debounce
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= '0;
         sync2  <= '0;
         brk1   <= 1'b0;
         brk2   <= 1'b0;
         db_lvl <= '0;
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         brk1  <= bus.brake_in;
         brk2  <= brk1;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] != db_lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_lvl[i] <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // press fires in the cycle whose edge flips the debounced level 0->1
   always_comb begin
      press = '0;
      for (int i = 0; i < NB; i++)
         press[i] = sync2[i] & ~db_lvl[i] & (db_cnt[i] == DB_LAST);
   end

   assign ev_set    = press[0] & ~brk2;
   assign ev_resume = press[1] & ~brk2;
   assign ev_accel  = press[2] & ~brk2;
   assign ev_coast  = press[3] & ~brk2;
   assign ev_cancel = press[4];

   // arbitration; speed requests are masked under brake since they are being flushed
   assign idle        = (state == IDLE);
   assign set_ok      = (bus.spd >= MIN_SPD);
   assign take_cancel = idle & flag_cancel;
   assign take_set    = idle & ~flag_cancel & flag_set & ~brk2;
   assign take_resume = idle & ~flag_cancel & ~(flag_set & ~brk2) & flag_resume & ~brk2;
   assign take_accel  = idle & ~flag_cancel & ~brk2 & ~flag_set & ~flag_resume &
                        (pend_accel != '0);
   assign take_coast  = idle & ~flag_cancel & ~brk2 & ~flag_set & ~flag_resume &
                        (pend_accel == '0) & (pend_coast != '0);

   always_comb begin
      flag_set_nxt    = (flag_set & ~take_set) | ev_set;
      flag_resume_nxt = (flag_resume & ~take_resume) | ev_resume;
      flag_cancel_nxt = (flag_cancel & ~take_cancel) | ev_cancel;

      // consume first, so a press in the same cycle sees the post-grant depth
      acc_eff = pend_accel - PW'(take_accel);
      coa_eff = pend_coast - PW'(take_coast);
      acc_nxt = acc_eff;
      coa_nxt = coa_eff;
      if (ev_accel && !ev_coast) begin
         if (coa_eff != '0)      coa_nxt = coa_eff - 1'b1;
         else if (acc_eff != PMAX) acc_nxt = acc_eff + 1'b1;
      end else if (ev_coast && !ev_accel) begin
         if (acc_eff != '0)      acc_nxt = acc_eff - 1'b1;
         else if (coa_eff != PMAX) coa_nxt = coa_eff + 1'b1;
      end

      if (brk2) begin
         flag_set_nxt    = 1'b0;
         flag_resume_nxt = 1'b0;
         acc_nxt         = '0;
         coa_nxt         = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_set    <= 1'b0;
         flag_resume <= 1'b0;
         flag_cancel <= 1'b0;
         pend_accel  <= '0;
         pend_coast  <= '0;
      end else begin
         flag_set    <= flag_set_nxt;
         flag_resume <= flag_resume_nxt;
         flag_cancel <= flag_cancel_nxt;
         pend_accel  <= acc_nxt;
         pend_coast  <= coa_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         cmd_q     <= '0;
         set_rej_q <= 1'b0;
      end else begin
         cmd_q     <= '0;
         set_rej_q <= 1'b0;
         case (state)
            IDLE: begin
               if (take_cancel) begin
                  cmd_q[4] <= 1'b1;
                  state    <= ISSUE;
               end else if (take_set) begin
                  if (set_ok) begin
                     cmd_q[0] <= 1'b1;
                     state    <= ISSUE;
                  end else begin
                     set_rej_q <= 1'b1;
                  end
               end else if (take_resume) begin
                  cmd_q[1] <= 1'b1;
                  state    <= ISSUE;
               end else if (take_accel) begin
                  cmd_q[2] <= 1'b1;
                  state    <= ISSUE;
               end else if (take_coast) begin
                  cmd_q[3] <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (GAP_CYC < 2) begin
                  state <= IDLE;
               end else begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_set    = cmd_q[0];
   assign bus.cmd_resume = cmd_q[1];
   assign bus.cmd_accel  = cmd_q[2];
   assign bus.cmd_coast  = cmd_q[3];
   assign bus.cmd_cancel = cmd_q[4];
   assign bus.set_rej    = set_rej_q;
   assign bus.brake_o    = brk2;
   assign bus.pend_accel = pend_accel;
   assign bus.pend_coast = pend_coast;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_ccc_cmd_arbiter.sv
// tb_ccc_cmd_arbiter
//   Directed bench. Instance A uses the default timing (DB_CYC=4, GAP_CYC=3).
//   Instance B uses DB_CYC=1, GAP_CYC=24 so a single gap is long enough to queue
//   several accel presses. Cycle k means k rising edges after the stimulus was applied.
module tb_ccc_cmd_arbiter;
   logic clk;
   logic rst_a, rst_b;
   int   n_chk, n_err;
   int   cyc;
   int   n_set_a, n_acc_a, n_coa_a, n_can_a;
   int   n_acc_b, n_can_b;
   int   onehot_err;
   int   acc_b_at[$];

   ccc_cmd_arbiter_if #(.PW(3)) bus_a ();
   ccc_cmd_arbiter_if #(.PW(3)) bus_b ();

   ccc_cmd_arbiter #(.DB_CYC(4), .GAP_CYC(3), .PW(3), .MIN_SET_SPD(40)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   ccc_cmd_arbiter #(.DB_CYC(1), .GAP_CYC(24), .PW(3), .MIN_SET_SPD(40)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus_a.cmd_set)    n_set_a++;
      if (bus_a.cmd_accel)  n_acc_a++;
      if (bus_a.cmd_coast)  n_coa_a++;
      if (bus_a.cmd_cancel) n_can_a++;
      if (bus_b.cmd_cancel) n_can_b++;
      if (bus_b.cmd_accel) begin
         n_acc_b++;
         acc_b_at.push_back(cyc);
      end
      if ($countones({bus_a.cmd_set, bus_a.cmd_resume, bus_a.cmd_accel,
                      bus_a.cmd_coast, bus_a.cmd_cancel}) > 1) onehot_err++;
      if ($countones({bus_b.cmd_set, bus_b.cmd_resume, bus_b.cmd_accel,
                      bus_b.cmd_coast, bus_b.cmd_cancel}) > 1) onehot_err++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_accel_b();
      bus_b.accel_in = 1'b1;
      tick(1);
      bus_b.accel_in = 1'b0;
      tick(1);
   endtask

   function automatic logic [31:0] outs_a();
      return 32'({bus_a.cmd_set, bus_a.cmd_resume, bus_a.cmd_accel, bus_a.cmd_coast,
                  bus_a.cmd_cancel, bus_a.set_rej, bus_a.brake_o, bus_a.busy,
                  bus_a.pend_accel, bus_a.pend_coast});
   endfunction

   function automatic logic [31:0] outs_b();
      return 32'({bus_b.cmd_set, bus_b.cmd_resume, bus_b.cmd_accel, bus_b.cmd_coast,
                  bus_b.cmd_cancel, bus_b.set_rej, bus_b.brake_o, bus_b.busy,
                  bus_b.pend_accel, bus_b.pend_coast});
   endfunction

   initial begin
      int  seen;
      n_chk = 0; n_err = 0; cyc = 0; onehot_err = 0;
      n_set_a = 0; n_acc_a = 0; n_coa_a = 0; n_can_a = 0; n_acc_b = 0; n_can_b = 0;
      {bus_a.set_in, bus_a.resume_in, bus_a.accel_in, bus_a.coast_in, bus_a.cancel_in,
       bus_a.brake_in} = '0;
      {bus_b.set_in, bus_b.resume_in, bus_b.accel_in, bus_b.coast_in, bus_b.cancel_in,
       bus_b.brake_in} = '0;
      bus_a.spd = 7'd0;
      bus_b.spd = 7'd50;
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick(3);
      chk("rst_a_outs", outs_a(), 32'd0);
      chk("rst_b_outs", outs_b(), 32'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick(3);
      chk("idle_a_outs", outs_a(), 32'd0);

      // set below minimum speed: rejected at cycle 7, no command
      bus_a.spd = 7'd30;
      bus_a.set_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (k == 8) bus_a.set_in = 1'b0;
         if (k == 6) chk("rej_c6", 32'(bus_a.set_rej), 32'd0);
         if (k == 7) begin
            chk("rej_c7", 32'(bus_a.set_rej), 32'd1);
            chk("rej_c7_busy", 32'(bus_a.busy), 32'd0);
         end
         if (k == 8) chk("rej_c8", 32'(bus_a.set_rej), 32'd0);
      end
      tick(12);
      chk("rej_no_set", 32'(n_set_a), 32'd0);

      // set above minimum speed: cmd_set at cycle 7
      bus_a.spd = 7'd50;
      bus_a.set_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (k == 6) chk("set_c6", 32'(bus_a.cmd_set), 32'd0);
         if (k == 7) chk("set_c7", 32'(bus_a.cmd_set), 32'd1);
         if (k == 8) begin
            chk("set_c8", 32'(bus_a.cmd_set), 32'd0);
            chk("set_c8_busy", 32'(bus_a.busy), 32'd1);
            bus_a.set_in = 1'b0;
         end
      end
      tick(15);
      chk("set_count", 32'(n_set_a), 32'd1);

      // bouncing accel never settles
      for (int k = 0; k < 12; k++) begin
         bus_a.accel_in = (k % 2 == 0);
         tick(1);
      end
      bus_a.accel_in = 1'b0;
      tick(20);
      chk("bounce_pend", 32'(bus_a.pend_accel), 32'd0);
      chk("bounce_cmds", 32'(n_acc_a), 32'd0);

      // cancel and coast together: cancel at 7, coast at 11
      bus_a.cancel_in = 1'b1;
      bus_a.coast_in  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (k == 6) begin
            bus_a.cancel_in = 1'b0;
            bus_a.coast_in  = 1'b0;
         end
         if (k == 7) begin
            chk("cc_c7_cancel", 32'(bus_a.cmd_cancel), 32'd1);
            chk("cc_c7_coast", 32'(bus_a.cmd_coast), 32'd0);
            chk("cc_c7_pend", 32'(bus_a.pend_coast), 32'd1);
         end
         if (k == 10) chk("cc_c10_coast", 32'(bus_a.cmd_coast), 32'd0);
         if (k == 11) begin
            chk("cc_c11_coast", 32'(bus_a.cmd_coast), 32'd1);
            chk("cc_c11_cancel", 32'(bus_a.cmd_cancel), 32'd0);
         end
      end
      tick(15);

      // accel press nets out the queued coast while cancel holds the bus
      bus_a.cancel_in = 1'b1;
      bus_a.coast_in  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (k == 2) bus_a.accel_in = 1'b1;
         if (k == 6) begin
            bus_a.cancel_in = 1'b0;
            bus_a.coast_in  = 1'b0;
         end
         if (k == 7) chk("net_c7_pend_coast", 32'(bus_a.pend_coast), 32'd1);
         if (k == 8) begin
            chk("net_c8_pend_coast", 32'(bus_a.pend_coast), 32'd0);
            chk("net_c8_pend_accel", 32'(bus_a.pend_accel), 32'd0);
            bus_a.accel_in = 1'b0;
         end
      end
      tick(20);
      chk("net_coast_cmds", 32'(n_coa_a), 32'd1);
      chk("net_accel_cmds", 32'(n_acc_a), 32'd0);
      chk("net_cancel_cmds", 32'(n_can_a), 32'd2);

      // reset in the middle of a gap with three accels queued
      press_accel_b();
      tick(2);
      chk("b_first_c4", 32'(bus_b.cmd_accel), 32'd1);
      repeat (3) press_accel_b();
      tick(2);
      chk("b_pend3", 32'(bus_b.pend_accel), 32'd3);
      chk("b_busy_gap", 32'(bus_b.busy), 32'd1);
      rst_b = 1'b0;
      tick(1);
      chk("b_rst_outs", outs_b(), 32'd0);
      rst_b = 1'b1;
      tick(40);
      chk("b_rst_no_stale", 32'(n_acc_b), 32'd1);
      chk("b_rst_outs_after", outs_b(), 32'd0);

      // brake flushes queued accels, cancel still goes through
      press_accel_b();
      tick(2);
      repeat (3) press_accel_b();
      tick(2);
      chk("brk_pend3", 32'(bus_b.pend_accel), 32'd3);
      bus_b.brake_in = 1'b1;
      tick(1);
      chk("brk_c1", 32'(bus_b.brake_o), 32'd0);
      tick(1);
      chk("brk_c2", 32'(bus_b.brake_o), 32'd1);
      tick(1);
      chk("brk_c3_pend", 32'(bus_b.pend_accel), 32'd0);
      bus_b.cancel_in = 1'b1;
      tick(1);
      bus_b.cancel_in = 1'b0;
      seen = 0;
      for (int k = 0; k < 60 && seen == 0; k++) begin
         tick(1);
         if (bus_b.cmd_cancel) seen = 1;
      end
      chk("brk_cancel_issued", 32'(seen), 32'd1);
      press_accel_b();
      tick(5);
      chk("brk_accel_dropped", 32'(bus_b.pend_accel), 32'd0);
      bus_b.brake_in = 1'b0;
      tick(60);
      chk("brk_no_accel", 32'(n_acc_b), 32'd2);

      // nine presses in one long gap saturate at 7, then 7 spaced pulses
      acc_b_at.delete();
      press_accel_b();
      tick(2);
      chk("sat_first", 32'(bus_b.cmd_accel), 32'd1);
      repeat (9) press_accel_b();
      tick(2);
      chk("sat_pend7", 32'(bus_b.pend_accel), 32'd7);
      tick(200);
      chk("sat_pulses", 32'(acc_b_at.size()), 32'd8);
      for (int i = 1; i < acc_b_at.size() && i < 8; i++)
         chk($sformatf("sat_gap%0d", i), 32'(acc_b_at[i] - acc_b_at[i-1]), 32'd25);
      chk("sat_pend_end", 32'(bus_b.pend_accel), 32'd0);

      chk("onehot", 32'(onehot_err), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
